// File: rtl/if_fetch_stage.sv
// if_fetch_stage: program counter, imem req/ready fetch FSM and 2-entry fetch queue feeding IF/ID
// Ports: clk, rst (sync, active-low); freeze stalls consumption of the head entry;
//   branch_taken/branch_address redirect the PC and flush the queue; imem_req/imem_addr/imem_ready/
//   imem_rdata form the instruction-memory handshake; PC/Instruction present the head (pc+4, word);
//   inst_valid flags a non-empty queue and fetch_stall is its inverse.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        inst_valid,
  output logic        fetch_stall
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t      state, state_nx;
  logic [31:0] pc, pc_inc, drain_addr, br_target;
  logic [1:0]  count, cnt_ap, count_nx;
  logic        pop, push;
  logic [31:0] q_inst [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  assign inst_valid  = count != 2'd0;
  assign fetch_stall = ~inst_valid;
  assign pop         = inst_valid & ~freeze & ~branch_taken;
  assign cnt_ap      = count - {1'b0, pop};
  assign push        = (state == REQ) & imem_ready & ~branch_taken;
  assign count_nx    = branch_taken ? 2'd0 : cnt_ap + {1'b0, push};
  assign pc_inc      = pc + 32'd4;
  assign br_target   = branch_address & ~32'd3;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      count      <= 2'd0;
      drain_addr <= 32'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pc    <= branch_taken ? br_target : push ? pc_inc : pc;
      // the killed request's address must stay on the bus until memory answers it
      if (state == REQ && branch_taken && !imem_ready) drain_addr <= pc;
    end
  end
  // head is always entry 0; a push lands behind whatever survives the pop
  always_ff @(posedge clk) begin
    if (pop) begin
      q_inst[0] <= q_inst[1];
      q_pc[0]   <= q_pc[1];
    end
    if (push) begin
      q_inst[cnt_ap[0]] <= imem_rdata;
      q_pc[cnt_ap[0]]   <= pc_inc;
    end
  end
  // a branch that meets the answer to an outstanding request needs no drain
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (branch_taken || cnt_ap <= 2'd1) ? REQ : IDLE;
      REQ:     state_nx = (branch_taken && !imem_ready) ? DRAIN : (count_nx <= 2'd1) ? REQ : IDLE;
      DRAIN:   state_nx = imem_ready ? REQ : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    imem_req    = state != IDLE;
    imem_addr   = (state == DRAIN) ? drain_addr : pc;
    Instruction = inst_valid ? q_inst[0] : 32'd0;
    PC          = inst_valid ? q_pc[0] : 32'd0;
  end
  assert property (@(posedge clk) disable iff (!rst) !(push && cnt_ap == 2'(QDEPTH)));
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed tests of streaming, freeze, branch redirect, PC wrap and mid-request reset
module tb_if_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 0, rst = 0, freeze = 0, branch_taken = 0;
  logic [31:0] branch_address = 0;
  logic        imem_req, imem_ready, inst_valid, fetch_stall;
  logic [31:0] imem_addr, imem_rdata, PC, Instruction;
  logic        w_req, w_ready, w_valid, w_stall;
  logic [31:0] w_addr, w_rdata, w_pc, w_inst;
  int lat = 0, wcnt = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign imem_ready = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr ^ K;
  always_ff @(posedge clk) wcnt <= (!imem_req || imem_ready) ? 0 : wcnt + 1;
  assign w_ready = w_req;
  assign w_rdata = w_addr ^ K;
  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_address(branch_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PC(PC), .Instruction(Instruction), .inst_valid(inst_valid), .fetch_stall(fetch_stall));
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_address(branch_address),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .PC(w_pc), .Instruction(w_inst), .inst_valid(w_valid), .fetch_stall(w_stall));
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 0;
    tick();
    tick();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    tests++; if (Instruction !== 32'd0) begin fails++; $display("FAIL reset_inst got %h want 0", Instruction); end
    tests++; if (PC !== 32'd0) begin fails++; $display("FAIL reset_pc got %h want 0", PC); end
    tests++; if (fetch_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b want 1", fetch_stall); end
  endtask
  task automatic test_stream;
    rst = 1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stream_c0_req got %b want 0", imem_req); end
    tick();
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stream_c1_req got %b want 1", imem_req); end
    tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL stream_c1_addr got %h want 0", imem_addr); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL stream_c1_valid got %b want 0", inst_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", k, inst_valid); end
      tests++; if (PC !== 32'(4 * (k + 1))) begin fails++; $display("FAIL stream_pc[%0d] got %h want %h", k, PC, 32'(4 * (k + 1))); end
      tests++; if (Instruction !== (32'(4 * k) ^ K)) begin fails++; $display("FAIL stream_inst[%0d] got %h want %h", k, Instruction, 32'(4 * k) ^ K); end
      tests++; if (imem_addr !== 32'(4 * (k + 1))) begin fails++; $display("FAIL stream_addr[%0d] got %h want %h", k, imem_addr, 32'(4 * (k + 1))); end
    end
  endtask
  task automatic test_freeze;
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL freeze_req[%0d] got %b want 0", i, imem_req); end
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL freeze_valid[%0d] got %b want 1", i, inst_valid); end
      tests++; if (PC !== 32'd24) begin fails++; $display("FAIL freeze_pc[%0d] got %h want 18", i, PC); end
      tests++; if (Instruction !== (32'd20 ^ K)) begin fails++; $display("FAIL freeze_inst[%0d] got %h want %h", i, Instruction, 32'd20 ^ K); end
    end
    freeze = 0;
    tick();
    tests++; if (PC !== 32'd28) begin fails++; $display("FAIL unfreeze_pc0 got %h want 1c", PC); end
    tests++; if (Instruction !== (32'd24 ^ K)) begin fails++; $display("FAIL unfreeze_inst0 got %h want %h", Instruction, 32'd24 ^ K); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL unfreeze_req got %b want 1", imem_req); end
    tests++; if (imem_addr !== 32'd28) begin fails++; $display("FAIL unfreeze_addr got %h want 1c", imem_addr); end
    tick();
    tests++; if (PC !== 32'd32) begin fails++; $display("FAIL unfreeze_pc1 got %h want 20", PC); end
    tests++; if (Instruction !== (32'd28 ^ K)) begin fails++; $display("FAIL unfreeze_inst1 got %h want %h", Instruction, 32'd28 ^ K); end
    tests++; if (imem_addr !== 32'd32) begin fails++; $display("FAIL unfreeze_addr1 got %h want 20", imem_addr); end
  endtask
  task automatic test_latency_branch;
    int n;
    rst = 0;
    lat = 3;
    tick();
    tick();
    rst = 1;
    tick();
    tests++; if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin fails++; $display("FAIL lat_first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    branch_taken = 1;
    branch_address = 32'h103;
    tick();
    branch_taken = 0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL drain_req[%0d] got %b want 1", i, imem_req); end
      tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL drain_addr[%0d] got %h want 0", i, imem_addr); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL drain_valid[%0d] got %b want 0", i, inst_valid); end
      tick();
    end
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL redirect_addr got %h want 100", imem_addr); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redirect_valid got %b want 0", inst_valid); end
    n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!inst_valid) begin
      fails++;
      $display("FAIL redirect_timeout got valid=%b want 1 within 20 cycles", inst_valid);
    end else begin
      tests++; if (PC !== 32'h104) begin fails++; $display("FAIL redirect_pc got %h want 104", PC); end
      tests++; if (Instruction !== (32'h100 ^ K)) begin fails++; $display("FAIL redirect_inst got %h want %h", Instruction, 32'h100 ^ K); end
    end
  endtask
  task automatic test_branch_ready;
    lat = 0;
    branch_taken = 1;
    branch_address = 32'h40;
    tick();
    branch_taken = 0;
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL brr_addr got %h want 40", imem_addr); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL brr_req got %b want 1", imem_req); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL brr_valid got %b want 0", inst_valid); end
    tests++; if (Instruction !== 32'd0 || PC !== 32'd0) begin fails++; $display("FAIL brr_nop got inst=%h pc=%h want 0/0", Instruction, PC); end
    tick();
    tests++; if (PC !== 32'h44) begin fails++; $display("FAIL brr_pc got %h want 44", PC); end
    tests++; if (Instruction !== (32'h40 ^ K)) begin fails++; $display("FAIL brr_inst got %h want %h", Instruction, 32'h40 ^ K); end
  endtask
  task automatic test_wrap;
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
    tests++; if (w_addr !== 32'hFFFF_FFF8 || w_req !== 1'b1) begin fails++; $display("FAIL wrap_addr0 got req=%b addr=%h want 1/fffffff8", w_req, w_addr); end
    tick();
    tests++; if (w_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr1 got %h want fffffffc", w_addr); end
    tests++; if (w_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc0 got %h want fffffffc", w_pc); end
    tests++; if (w_inst !== (32'hFFFF_FFF8 ^ K)) begin fails++; $display("FAIL wrap_inst0 got %h want %h", w_inst, 32'hFFFF_FFF8 ^ K); end
    tick();
    tests++; if (w_addr !== 32'd0) begin fails++; $display("FAIL wrap_addr2 got %h want 0", w_addr); end
    tests++; if (w_pc !== 32'd0 || w_valid !== 1'b1) begin fails++; $display("FAIL wrap_pc1 got pc=%h valid=%b want 0/1", w_pc, w_valid); end
    tests++; if (w_inst !== (32'hFFFF_FFFC ^ K)) begin fails++; $display("FAIL wrap_inst1 got %h want %h", w_inst, 32'hFFFF_FFFC ^ K); end
    tick();
    tests++; if (w_pc !== 32'd4) begin fails++; $display("FAIL wrap_pc2 got %h want 4", w_pc); end
    tests++; if (w_inst !== K) begin fails++; $display("FAIL wrap_inst2 got %h want %h", w_inst, K); end
    tests++; if (w_addr !== 32'd4) begin fails++; $display("FAIL wrap_addr3 got %h want 4", w_addr); end
  endtask
  task automatic test_reset_mid;
    rst = 0;
    tick();
    tick();
    lat = 4;
    rst = 1;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL rmid_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    tick();
    rst = 0;
    tick();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rmid_drop got %b want 0", imem_req); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", inst_valid); end
    tests++; if (Instruction !== 32'd0) begin fails++; $display("FAIL rmid_inst got %h want 0", Instruction); end
    tests++; if (fetch_stall !== 1'b1) begin fails++; $display("FAIL rmid_stall got %b want 1", fetch_stall); end
    rst = 1;
    lat = 0;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL rmid_restart got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    tick();
    tests++; if (inst_valid !== 1'b1 || PC !== 32'd4) begin fails++; $display("FAIL rmid_first got valid=%b pc=%h want 1/4", inst_valid, PC); end
    tests++; if (Instruction !== K) begin fails++; $display("FAIL rmid_first_inst got %h want %h", Instruction, K); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_latency_branch();
    test_branch_ready();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
